// File: rtl/cpu_pkg.sv
// Shared opcode constants, sequencer state encoding, instruction classes and
// bus/load-enable bit positions for the control unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    IC_NOP, IC_ALU, IC_IMM, IC_NEGNOT, IC_LD, IC_LDI, IC_ST, IC_BR,
    IC_JR, IC_JAL, IC_IN, IC_OUT, IC_MFHI, IC_MFLO, IC_MULDIV, IC_HALT
  } iclass_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int unsigned BUS_W = 8;
  localparam int unsigned RIN_W = 10;

  // bus_out_en bit positions
  localparam int unsigned BUS_HI  = 7;
  localparam int unsigned BUS_LO  = 6;
  localparam int unsigned BUS_ZHI = 5;
  localparam int unsigned BUS_ZLO = 4;
  localparam int unsigned BUS_PC  = 3;
  localparam int unsigned BUS_MDR = 2;
  localparam int unsigned BUS_INP = 1;
  localparam int unsigned BUS_C   = 0;

  // reg_in_en bit positions
  localparam int unsigned RIN_HI   = 9;
  localparam int unsigned RIN_LO   = 8;
  localparam int unsigned RIN_ZHI  = 7;
  localparam int unsigned RIN_ZLO  = 6;
  localparam int unsigned RIN_PC   = 5;
  localparam int unsigned RIN_MDR  = 4;
  localparam int unsigned RIN_OUTP = 3;
  localparam int unsigned RIN_Y    = 2;
  localparam int unsigned RIN_MAR  = 1;
  localparam int unsigned RIN_IR   = 0;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier. MUL_DIV_EN selects whether mul/div are
// real instructions or fall back to nop.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass
);

  always_comb begin
    iclass = IC_NOP;
    if (opcode >= OP_ADD && opcode <= OP_ROL) begin
      iclass = IC_ALU;
    end else if (opcode >= OP_ADDI && opcode <= OP_ORI) begin
      iclass = IC_IMM;
    end else begin
      case (opcode)
        OP_LD:          iclass = IC_LD;
        OP_LDI:         iclass = IC_LDI;
        OP_ST:          iclass = IC_ST;
        OP_MUL, OP_DIV: begin
`ifdef MUL_DIV_EN
          iclass = IC_MULDIV;
`else
          iclass = IC_NOP;
`endif
        end
        OP_NEG, OP_NOT: iclass = IC_NEGNOT;
        OP_BR:          iclass = IC_BR;
        OP_JR:          iclass = IC_JR;
        OP_JAL:         iclass = IC_JAL;
        OP_IN:          iclass = IC_IN;
        OP_OUT:         iclass = IC_OUT;
        OP_MFHI:        iclass = IC_MFHI;
        OP_MFLO:        iclass = IC_MFLO;
        OP_HALT:        iclass = IC_HALT;
        default:        iclass = IC_NOP;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired T0..T7 sequencer with HALT state. Optional mul/div sequences are
// enabled by defining MUL_DIV_EN.
module control_unit
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       ir,
  input  logic              branch_compare,
  input  logic              stop,
  output logic              gra,
  output logic              grb,
  output logic              grc,
  output logic              rin,
  output logic              rout,
  output logic              ba_out,
  output logic [BUS_W-1:0]  bus_out_en,
  output logic [RIN_W-1:0]  reg_in_en,
  output logic              read,
  output logic              write,
  output logic              inc_pc,
  output logic              con_in,
  output logic [4:0]        alu_op,
  output logic              run
);

  state_t     state, state_next;
  logic       halt_lock, lock_next;
  logic       done;
  logic [4:0] op_q, opcode;
  iclass_t    iclass;
  logic       ir_unused;

  assign ir_unused = ^ir[26:0];

  // Opcode is taken live in T3 and held for the remaining steps
  assign opcode = (state == S_T3) ? ir[31:27] : op_q;

  instr_class_decode u_decode (
    .opcode (opcode),
    .iclass (iclass)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= S_T0;
      halt_lock <= 1'b0;
    end else begin
      state     <= state_next;
      halt_lock <= lock_next;
    end
  end

  always_ff @(posedge clock) begin
    if (state == S_T3) op_q <= ir[31:27];
  end

  always_comb begin
    state_next = state;
    lock_next  = halt_lock;
    done       = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; ba_out = 1'b0;
    bus_out_en = '0;
    reg_in_en  = '0;
    read = 1'b0; write = 1'b0; inc_pc = 1'b0; con_in = 1'b0;
    alu_op = '0;
    run    = 1'b1;

    case (state)
      S_T0: begin
        bus_out_en[BUS_PC] = 1'b1;
        reg_in_en[RIN_MAR] = 1'b1;
        reg_in_en[RIN_ZLO] = 1'b1;
        inc_pc     = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        bus_out_en[BUS_ZLO] = 1'b1;
        reg_in_en[RIN_PC]   = 1'b1;
        reg_in_en[RIN_MDR]  = 1'b1;
        read       = 1'b1;
        state_next = S_T2;
      end
      S_T2: begin
        bus_out_en[BUS_MDR] = 1'b1;
        reg_in_en[RIN_IR]   = 1'b1;
        state_next = S_T3;
      end
      S_HALT: begin
        run = 1'b0;
        if (!halt_lock && !stop) state_next = S_T0;
      end
      default: begin
        // Execute steps advance by one; the last step of each class sets done
        state_next = state_t'({1'b0, state[2:0] + 3'd1});
        case (iclass)
          IC_ALU, IC_IMM: begin
            case (state)
              S_T3: begin grb = 1'b1; rout = 1'b1; reg_in_en[RIN_Y] = 1'b1; end
              S_T4: begin
                if (iclass == IC_ALU) begin grc = 1'b1; rout = 1'b1; end
                else bus_out_en[BUS_C] = 1'b1;
                alu_op = opcode;
                reg_in_en[RIN_ZLO] = 1'b1;
              end
              default: begin
                bus_out_en[BUS_ZLO] = 1'b1; gra = 1'b1; rin = 1'b1; done = 1'b1;
              end
            endcase
          end
          IC_NEGNOT: begin
            if (state == S_T3) begin
              grb = 1'b1; rout = 1'b1; alu_op = opcode; reg_in_en[RIN_ZLO] = 1'b1;
            end else begin
              bus_out_en[BUS_ZLO] = 1'b1; gra = 1'b1; rin = 1'b1; done = 1'b1;
            end
          end
          IC_LD, IC_LDI, IC_ST: begin
            case (state)
              S_T3: begin grb = 1'b1; ba_out = 1'b1; reg_in_en[RIN_Y] = 1'b1; end
              S_T4: begin
                bus_out_en[BUS_C] = 1'b1; alu_op = OP_ADD; reg_in_en[RIN_ZLO] = 1'b1;
              end
              S_T5: begin
                bus_out_en[BUS_ZLO] = 1'b1;
                if (iclass == IC_LDI) begin gra = 1'b1; rin = 1'b1; done = 1'b1; end
                else reg_in_en[RIN_MAR] = 1'b1;
              end
              S_T6: begin
                if (iclass == IC_ST) begin
                  gra = 1'b1; rout = 1'b1; write = 1'b1; done = 1'b1;
                end else begin
                  read = 1'b1; reg_in_en[RIN_MDR] = 1'b1;
                end
              end
              default: begin
                bus_out_en[BUS_MDR] = 1'b1; gra = 1'b1; rin = 1'b1; done = 1'b1;
              end
            endcase
          end
          IC_BR: begin
            case (state)
              S_T3: begin gra = 1'b1; rout = 1'b1; con_in = 1'b1; end
              S_T4: begin bus_out_en[BUS_PC] = 1'b1; reg_in_en[RIN_Y] = 1'b1; end
              S_T5: begin
                bus_out_en[BUS_C] = 1'b1; alu_op = OP_ADD; reg_in_en[RIN_ZLO] = 1'b1;
              end
              default: begin
                if (branch_compare) begin
                  bus_out_en[BUS_ZLO] = 1'b1; reg_in_en[RIN_PC] = 1'b1;
                end
                done = 1'b1;
              end
            endcase
          end
          IC_JR: begin gra = 1'b1; rout = 1'b1; reg_in_en[RIN_PC] = 1'b1; done = 1'b1; end
          IC_JAL: begin
            // Link step: PC onto the bus with rin while the select logic forces R15
            if (state == S_T3) begin
              bus_out_en[BUS_PC] = 1'b1; rin = 1'b1;
            end else begin
              gra = 1'b1; rout = 1'b1; reg_in_en[RIN_PC] = 1'b1; done = 1'b1;
            end
          end
          IC_IN:   begin bus_out_en[BUS_INP] = 1'b1; gra = 1'b1; rin = 1'b1; done = 1'b1; end
          IC_OUT:  begin gra = 1'b1; rout = 1'b1; reg_in_en[RIN_OUTP] = 1'b1; done = 1'b1; end
          IC_MFHI: begin bus_out_en[BUS_HI] = 1'b1; gra = 1'b1; rin = 1'b1; done = 1'b1; end
          IC_MFLO: begin bus_out_en[BUS_LO] = 1'b1; gra = 1'b1; rin = 1'b1; done = 1'b1; end
`ifdef MUL_DIV_EN
          IC_MULDIV: begin
            case (state)
              S_T3: begin gra = 1'b1; rout = 1'b1; reg_in_en[RIN_Y] = 1'b1; end
              S_T4: begin
                grb = 1'b1; rout = 1'b1; alu_op = opcode;
                reg_in_en[RIN_ZLO] = 1'b1; reg_in_en[RIN_ZHI] = 1'b1;
              end
              S_T5: begin bus_out_en[BUS_ZLO] = 1'b1; reg_in_en[RIN_LO] = 1'b1; end
              default: begin
                bus_out_en[BUS_ZHI] = 1'b1; reg_in_en[RIN_HI] = 1'b1; done = 1'b1;
              end
            endcase
          end
`endif
          IC_HALT: begin
            state_next = S_HALT;
            lock_next  = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
    endcase

    if (done) state_next = stop ? S_HALT : S_T0;

    // Reset forces every strobe low immediately, independent of the clock
    if (!clear) begin
      gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; ba_out = 1'b0;
      bus_out_en = '0;
      reg_in_en  = '0;
      read = 1'b0; write = 1'b0; inc_pc = 1'b0; con_in = 1'b0;
      alu_op = '0;
      run    = 1'b1;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction micro-step tables as reference,
// directed literal scenarios, then randomized instruction/stop/clear traffic.
module tb_control_unit;

  typedef struct packed {
    logic       gra, grb, grc, rin, rout, ba;
    logic [7:0] bus;
    logic [9:0] ins;
    logic       read, write, inc, con;
    logic [4:0] alu;
    logic       run;
  } ctl_t;

  localparam int HI_O = 7, LO_O = 6, ZH_O = 5, ZL_O = 4, PC_O = 3, MDR_O = 2, IN_O = 1, C_O = 0;
  localparam int HI_I = 9, LO_I = 8, ZH_I = 7, ZL_I = 6, PC_I = 5, MDR_I = 4, OUT_I = 3,
                 Y_I = 2, MAR_I = 1, IR_I = 0;
`ifdef MUL_DIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        branch_compare, stop;
  logic        gra, grb, grc, rin, rout, ba_out, read, write, inc_pc, con_in, run;
  logic [7:0]  bus_out_en;
  logic [9:0]  reg_in_en;
  logic [4:0]  alu_op;
  ctl_t        dut_w;

  int checks = 0;
  int failures = 0;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .branch_compare(branch_compare), .stop(stop),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .ba_out(ba_out),
    .bus_out_en(bus_out_en), .reg_in_en(reg_in_en), .read(read), .write(write),
    .inc_pc(inc_pc), .con_in(con_in), .alu_op(alu_op), .run(run)
  );

  always #5 clock = ~clock;

  assign dut_w = {gra, grb, grc, rin, rout, ba_out, bus_out_en, reg_in_en,
                  read, write, inc_pc, con_in, alu_op, run};

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  // ---------------- reference tables ----------------
  function automatic int last_step(input logic [4:0] op);
    int o = int'(op);
    if (o == 0) return 7;
    if (o == 1) return 5;
    if (o == 2) return 6;
    if (o >= 3 && o <= 14) return 5;
    if ((o == 15 || o == 16) && MD) return 6;
    if (o == 17 || o == 18) return 4;
    if (o == 19) return 6;
    if (o == 21) return 4;
    return 3;
  endfunction

  function automatic ctl_t fetch_w(input int k);
    ctl_t w = '0;
    w.run = 1'b1;
    if (k == 0) begin w.bus[PC_O] = 1; w.ins[MAR_I] = 1; w.ins[ZL_I] = 1; w.inc = 1; end
    else if (k == 1) begin w.bus[ZL_O] = 1; w.ins[PC_I] = 1; w.ins[MDR_I] = 1; w.read = 1; end
    else begin w.bus[MDR_O] = 1; w.ins[IR_I] = 1; end
    return w;
  endfunction

  function automatic ctl_t exec_w(input logic [4:0] op, input int k, input logic bc);
    ctl_t w = '0;
    int o = int'(op);
    w.run = 1'b1;
    if (o >= 3 && o <= 14) begin
      if (k == 3) begin w.grb = 1; w.rout = 1; w.ins[Y_I] = 1; end
      if (k == 4) begin
        if (o <= 11) begin w.grc = 1; w.rout = 1; end else w.bus[C_O] = 1;
        w.alu = op; w.ins[ZL_I] = 1;
      end
      if (k == 5) begin w.bus[ZL_O] = 1; w.gra = 1; w.rin = 1; end
    end else if (o <= 2) begin
      if (k == 3) begin w.grb = 1; w.ba = 1; w.ins[Y_I] = 1; end
      if (k == 4) begin w.bus[C_O] = 1; w.alu = 5'd3; w.ins[ZL_I] = 1; end
      if (k == 5) begin
        w.bus[ZL_O] = 1;
        if (o == 1) begin w.gra = 1; w.rin = 1; end else w.ins[MAR_I] = 1;
      end
      if (k == 6 && o == 0) begin w.read = 1; w.ins[MDR_I] = 1; end
      if (k == 6 && o == 2) begin w.gra = 1; w.rout = 1; w.write = 1; end
      if (k == 7) begin w.bus[MDR_O] = 1; w.gra = 1; w.rin = 1; end
    end else if ((o == 15 || o == 16) && MD) begin
      if (k == 3) begin w.gra = 1; w.rout = 1; w.ins[Y_I] = 1; end
      if (k == 4) begin w.grb = 1; w.rout = 1; w.alu = op; w.ins[ZL_I] = 1; w.ins[ZH_I] = 1; end
      if (k == 5) begin w.bus[ZL_O] = 1; w.ins[LO_I] = 1; end
      if (k == 6) begin w.bus[ZH_O] = 1; w.ins[HI_I] = 1; end
    end else if (o == 17 || o == 18) begin
      if (k == 3) begin w.grb = 1; w.rout = 1; w.alu = op; w.ins[ZL_I] = 1; end
      if (k == 4) begin w.bus[ZL_O] = 1; w.gra = 1; w.rin = 1; end
    end else if (o == 19) begin
      if (k == 3) begin w.gra = 1; w.rout = 1; w.con = 1; end
      if (k == 4) begin w.bus[PC_O] = 1; w.ins[Y_I] = 1; end
      if (k == 5) begin w.bus[C_O] = 1; w.alu = 5'd3; w.ins[ZL_I] = 1; end
      if (k == 6 && bc) begin w.bus[ZL_O] = 1; w.ins[PC_I] = 1; end
    end else if (o == 20) begin
      w.gra = 1; w.rout = 1; w.ins[PC_I] = 1;
    end else if (o == 21) begin
      if (k == 3) begin w.bus[PC_O] = 1; w.rin = 1; end
      else begin w.gra = 1; w.rout = 1; w.ins[PC_I] = 1; end
    end else if (o == 22) begin w.bus[IN_O] = 1; w.gra = 1; w.rin = 1; end
    else if (o == 23) begin w.gra = 1; w.rout = 1; w.ins[OUT_I] = 1; end
    else if (o == 24) begin w.bus[HI_O] = 1; w.gra = 1; w.rin = 1; end
    else if (o == 25) begin w.bus[LO_O] = 1; w.gra = 1; w.rin = 1; end
    return w;
  endfunction

  // ---------------- reference state ----------------
  int         m_step = 0;
  bit         m_halt = 0, m_lock = 0;
  logic [4:0] m_op = '0;
  logic [4:0] cur_op;

  assign cur_op = (m_step == 3) ? ir[31:27] : m_op;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_step <= 0; m_halt <= 0; m_lock <= 0;
    end else if (m_halt) begin
      if (!m_lock && !stop) begin m_halt <= 0; m_step <= 0; end
    end else begin
      if (m_step == 3) m_op <= cur_op;
      if (m_step == 3 && cur_op == 5'd27) begin
        m_halt <= 1; m_lock <= 1;
      end else if (m_step >= 3 && m_step == last_step(cur_op)) begin
        if (stop) m_halt <= 1; else m_step <= 0;
      end else begin
        m_step <= m_step + 1;
      end
    end
  end

  function automatic ctl_t expect_w();
    ctl_t w = '0;
    if (!clear) begin w.run = 1'b1; return w; end
    if (m_halt) return w;
    if (m_step < 3) return fetch_w(m_step);
    return exec_w(cur_op, m_step, branch_compare);
  endfunction

  always @(negedge clock) begin
    check("model_word", 64'(dut_w), 64'(expect_w()));
    check("bus_onehot", 64'($countones(bus_out_en) <= 1), 64'd1);
    check("bus_vs_rout", 64'((bus_out_en != 0) && rout), 64'd0);
    check("read_write", 64'(read && write), 64'd0);
  end

  // ---------------- directed helpers ----------------
  task automatic reset_release();
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b1;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  logic [31:0] r;

  initial begin
    clear = 1'b0; ir = 32'h18918000; branch_compare = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check("reset_run", 64'(run), 64'd1);
    check("reset_bus", 64'(bus_out_en), 64'd0);
    check("reset_regin", 64'(reg_in_en), 64'd0);

    // add R1,R2,R3
    reset_release();
    check("add_t0_bus", 64'(bus_out_en), 64'h08);
    check("add_t0_in", 64'(reg_in_en), 64'h042);
    check("add_t0_inc", 64'(inc_pc), 64'd1);
    next_cycle();
    check("add_t1_bus", 64'(bus_out_en), 64'h10);
    check("add_t1_in", 64'(reg_in_en), 64'h030);
    check("add_t1_read", 64'(read), 64'd1);
    next_cycle();
    check("add_t2", 64'({bus_out_en, reg_in_en}), 64'({8'h04, 10'h001}));
    next_cycle();
    check("add_t3", 64'({grb, rout, reg_in_en}), 64'({2'b11, 10'h004}));
    next_cycle();
    check("add_t4", 64'({grc, rout, alu_op, reg_in_en}), 64'({2'b11, 5'b00011, 10'h040}));
    next_cycle();
    check("add_t5", 64'({gra, rin, bus_out_en, reg_in_en}), 64'({2'b11, 8'h10, 10'h000}));
    next_cycle();
    check("add_t0_again", 64'(bus_out_en), 64'h08);

    // br, not taken then taken
    for (int t = 0; t < 2; t++) begin
      ir = 32'h9A880004; branch_compare = t[0];
      reset_release();
      repeat (3) next_cycle();
      check("br_t3_con", 64'({gra, rout, con_in}), 64'h7);
      repeat (3) next_cycle();
      check("br_t6", 64'({bus_out_en, reg_in_en}), t == 0 ? 64'd0 : 64'({8'h10, 10'h020}));
      next_cycle();
      check("br_back_t0", 64'(bus_out_en), 64'h08);
    end
    branch_compare = 1'b0;

    // halt opcode: sticky until clear
    ir = 32'hD8000000;
    reset_release();
    repeat (3) next_cycle();
    check("halt_t3_run", 64'(run), 64'd1);
    next_cycle();
    check("halt_c4_run", 64'(run), 64'd0);
    stop = 1'b1; next_cycle(); stop = 1'b0;
    repeat (2) next_cycle();
    check("halt_sticky", 64'({run, bus_out_en, reg_in_en}), 64'd0);
    clear = 1'b0; #1;
    check("halt_clear_run", 64'(run), 64'd1);
    ir = 32'h18918000;
    #1 clear = 1'b1; #1;
    check("halt_clear_t0", 64'(bus_out_en), 64'h08);

    // mul R3,R4
    ir = 32'h79A00000;
    reset_release();
    repeat (3) next_cycle();
    if (MD) begin
      check("mul_t3", 64'({gra, rout, reg_in_en}), 64'({2'b11, 10'h004}));
      repeat (2) next_cycle();
      check("mul_t5_lo", 64'(reg_in_en), 64'h100);
      next_cycle();
      check("mul_t6_hi", 64'({bus_out_en, reg_in_en}), 64'({8'h20, 10'h200}));
    end else begin
      check("mul_t3_idle", 64'({gra, rout, bus_out_en, reg_in_en, alu_op}), 64'd0);
      next_cycle();
      check("mul_t0", 64'(bus_out_en), 64'h08);
    end

    // stop raised during ld
    ir = 32'h00000000;
    reset_release();
    repeat (4) next_cycle();
    stop = 1'b1;
    repeat (2) next_cycle();
    check("ld_t6_read", 64'({read, reg_in_en}), 64'({1'b1, 10'h010}));
    next_cycle();
    check("ld_t7_wb", 64'({gra, rin, bus_out_en}), 64'({2'b11, 8'h04}));
    next_cycle();
    check("ld_halt_run", 64'(run), 64'd0);
    stop = 1'b0;
    next_cycle();
    check("ld_resume_t0", 64'({run, bus_out_en}), 64'({1'b1, 8'h08}));

    // clear during st T5
    ir = 32'h10000000;
    reset_release();
    repeat (5) next_cycle();
    check("st_t5", 64'({bus_out_en, reg_in_en}), 64'({8'h10, 10'h002}));
    clear = 1'b0; #1;
    check("st_clear_async", 64'(dut_w), 64'd1);
    next_cycle();
    check("st_no_write", 64'(write), 64'd0);
    clear = 1'b1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock);
      #1;
      r = $urandom;
      ir = r;
      stop = ($urandom_range(0, 7) == 0);
      branch_compare = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 49) != 0);
    end
    @(posedge clock);
    #1 clear = 1'b1;
    repeat (2) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
